bus_copy_master: RTL and testbench

Bus initiator that moves blocks of 32-bit words across the SoC data bus on its own, without the CPU. It drives the same address/write-enable/write-data/read-data bus the CPU drives into the Bridge, so it can reach DRAM and every memory-mapped peripheral. A request/grant pair lets an external arbiter multiplex it with the CPU. Its uses are memory copy and, optionally, block fill.

---
 rtl/bus_copy_master_if.sv | 25 ++
 rtl/bus_copy_master.sv | 150 +++++++++++++++
 tb/tb_bus_copy_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_copy_master_if.sv
// Bus interface between bus_copy_master and the SoC data bus / arbiter.
//   bus_req   : request to the arbiter (master -> arbiter)
//   bus_gnt   : grant from the arbiter (arbiter -> master)
//   Bus_addr  : word-aligned byte address (master -> bus)
//   Bus_we    : write enable; the write commits at the rising edge
//   Bus_wdata : write data (master -> bus)
//   Bus_rdata : read data, combinational from Bus_addr (bus -> master)
interface bus_copy_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] Bus_addr;
  logic        Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (
    output bus_req, Bus_addr, Bus_we, Bus_wdata,
    input  bus_gnt, Bus_rdata
  );

  modport slave (
    input  bus_req, Bus_addr, Bus_we, Bus_wdata,
    output bus_gnt, Bus_rdata
  );
endinterface

// File: rtl/bus_copy_master.sv
// bus_copy_master: autonomous block-copy initiator on the SoC data bus.
// Copies len 32-bit words from src_addr to dst_addr in ascending order,
// one read and one write per word, arbitrated against the CPU by a
// request/grant pair. Losing the grant freezes the current state.
//
// Optional feature macro: BUS_COPY_FILL_EN
//   Adds fill_mode/fill_data; in fill mode the read phase is skipped and
//   every destination word is written with the latched fill_data.
//
// Ports:
//   cpu_clk    : clock, rising edge
//   cpu_rstn   : asynchronous active-low reset
//   start      : one-cycle command strobe, honoured only in IDLE
//   src_addr   : source byte address (bits [1:0] forced to 0)
//   dst_addr   : destination byte address (bits [1:0] forced to 0)
//   len        : word count (0 completes immediately without bus use)
//   fill_mode  : (BUS_COPY_FILL_EN) select block fill instead of copy
//   fill_data  : (BUS_COPY_FILL_EN) fill pattern
//   bus        : bus_copy_master_if master modport (req/gnt + data bus)
//   busy       : high from REQ through WR
//   done       : one-cycle completion pulse
//   remaining  : words still to transfer (0 in IDLE and DONE)
module bus_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_W-1:0]     len,
`ifdef BUS_COPY_FILL_EN
  input  logic                 fill_mode,
  input  logic [31:0]          fill_data,
`endif
  bus_copy_master_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     remaining
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [31:0]      r_src_ptr;
  logic [31:0]      r_dst_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic             w_fill;
  logic             w_last;

`ifdef BUS_COPY_FILL_EN
  logic r_fill;
  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  assign w_last = (r_cnt == LEN_W'(1));

  // In fill mode the fill pattern is parked in r_buf at start; RD is never
  // entered, so the buffer is not overwritten and WR needs no extra mux.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state   <= S_IDLE;
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_cnt     <= '0;
      r_buf     <= '0;
`ifdef BUS_COPY_FILL_EN
      r_fill    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_ptr <= {src_addr[31:2], 2'b00};
            r_dst_ptr <= {dst_addr[31:2], 2'b00};
            r_cnt     <= len;
`ifdef BUS_COPY_FILL_EN
            r_fill    <= fill_mode;
            if (fill_mode) r_buf <= fill_data;
`endif
            r_state   <= (len == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (bus.bus_gnt) r_state <= w_fill ? S_WR : S_RD;
        end
        S_RD: begin
          if (bus.bus_gnt) begin
            r_buf   <= bus.Bus_rdata;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (bus.bus_gnt) begin
            r_src_ptr <= r_src_ptr + 32'd4;
            r_dst_ptr <= r_dst_ptr + 32'd4;
            r_cnt     <= r_cnt - LEN_W'(1);
            if (w_last)      r_state <= S_DONE;
            else if (w_fill) r_state <= S_WR;
            else             r_state <= S_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.bus_req   = 1'b0;
    bus.Bus_addr  = '0;
    bus.Bus_we    = 1'b0;
    bus.Bus_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    remaining     = '0;
    case (r_state)
      S_REQ: begin
        bus.bus_req = 1'b1;
        busy        = 1'b1;
        remaining   = r_cnt;
      end
      S_RD: begin
        bus.bus_req  = 1'b1;
        busy         = 1'b1;
        remaining    = r_cnt;
        bus.Bus_addr = r_src_ptr;
      end
      S_WR: begin
        bus.bus_req   = 1'b1;
        busy          = 1'b1;
        remaining     = r_cnt;
        bus.Bus_addr  = r_dst_ptr;
        bus.Bus_wdata = r_buf;
        // Write strobe gated by grant so a withdrawn grant never writes.
        bus.Bus_we    = bus.bus_gnt;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed testbench for bus_copy_master with a 4 KB word memory model.
module tb_bus_copy_master;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [15:0] remaining;
`ifdef BUS_COPY_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_data;
`endif

  bus_copy_master_if bif();

  bus_copy_master #(.LEN_W(16)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
`ifdef BUS_COPY_FILL_EN
    .fill_mode (fill_mode),
    .fill_data (fill_data),
`endif
    .bus       (bif),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  logic [31:0] mem [1024];
  int          wr_cnt [1024];
  int          wr_total;

  assign bif.Bus_rdata = mem[bif.Bus_addr[11:2]];

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  typedef logic flag_arr_t [32];
  flag_arr_t   s_req, s_we, s_busy, s_done;
  logic [31:0] s_addr  [32];
  logic [31:0] s_wdata [32];
  logic [15:0] s_rem   [32];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int count_of(input flag_arr_t a, input int n);
    int k = 0;
    for (int c = 1; c < n; c++) if (a[c]) k++;
    return k;
  endfunction

  function automatic int first_of(input flag_arr_t a, input int n);
    for (int c = 1; c < n; c++) if (a[c]) return c;
    return -1;
  endfunction

  function automatic int last_of(input flag_arr_t a, input int n);
    int l = -1;
    for (int c = 1; c < n; c++) if (a[c]) l = c;
    return l;
  endfunction

  task automatic clear_log();
    wr_total = 0;
    for (int i = 0; i < 1024; i++) wr_cnt[i] = 0;
  endtask

  // start is sampled at edge 0; cycle c is the period after edge c.
  // Per cycle: drive gnt/start/reset, settle, sample outputs, then apply
  // any write to the memory model (equivalent to committing at the edge).
  task automatic run_op(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                        input int stall_at, input int stall_len, input int restart_at,
                        input int rst_at, input int ncyc);
    clear_log();
    @(negedge cpu_clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1; bif.bus_gnt = 1'b1;
    @(posedge cpu_clk);
    for (int c = 1; c < ncyc; c++) begin
      if (c > 1) @(posedge cpu_clk);
      #1;
      bif.bus_gnt = !(c >= stall_at && c < stall_at + stall_len);
      start       = (c == restart_at);
      if (c == rst_at) cpu_rstn = 1'b0;
      #1;
      s_req[c]   = bif.bus_req;
      s_we[c]    = bif.Bus_we;
      s_addr[c]  = bif.Bus_addr;
      s_wdata[c] = bif.Bus_wdata;
      s_busy[c]  = busy;
      s_done[c]  = done;
      s_rem[c]   = remaining;
      if (bif.Bus_we) begin
        mem[bif.Bus_addr[11:2]] = bif.Bus_wdata;
        wr_cnt[bif.Bus_addr[11:2]]++;
        wr_total++;
      end
    end
    start = 1'b0;
    bif.bus_gnt = 1'b1;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  initial begin
    cpu_rstn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    bif.bus_gnt = 1'b1;
`ifdef BUS_COPY_FILL_EN
    fill_mode = 1'b0; fill_data = '0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear_log();
    #2;
    check_eq("rst_req",   32'(bif.bus_req), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_we",    32'(bif.Bus_we), 32'd0);
    check_eq("rst_addr",  bif.Bus_addr, 32'd0);
    check_eq("rst_wdata", bif.Bus_wdata, 32'd0);
    check_eq("rst_rem",   32'(remaining), 32'd0);
    repeat (2) @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    repeat (2) @(negedge cpu_clk);

    // Basic copy: 0x100..0x10C -> 0x200..0x20C
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'hA0 + 32'(i);
    run_op(32'h100, 32'h200, 16'd4, 0, 0, 0, 0, 16);
    for (int i = 0; i < 4; i++) check_eq($sformatf("copy_mem%0d", i), mem[128 + i], 32'hA0 + 32'(i));
    check_eq("copy_done_cyc",  32'(first_of(s_done, 16)), 32'd10);
    check_eq("copy_done_cnt",  32'(count_of(s_done, 16)), 32'd1);
    check_eq("copy_busy_cnt",  32'(count_of(s_busy, 16)), 32'd9);
    check_eq("copy_busy_1st",  32'(first_of(s_busy, 16)), 32'd1);
    check_eq("copy_busy_last", 32'(last_of(s_busy, 16)), 32'd9);
    check_eq("copy_rem_c1",    32'(s_rem[1]), 32'd4);
    check_eq("copy_rem_c4",    32'(s_rem[4]), 32'd3);
    check_eq("copy_rem_c10",   32'(s_rem[10]), 32'd0);
    check_eq("copy_rd_addr",   s_addr[2], 32'h100);
    check_eq("copy_rd_we",     32'(s_we[2]), 32'd0);
    check_eq("copy_wr_addr",   s_addr[3], 32'h200);
    check_eq("copy_wr_we",     32'(s_we[3]), 32'd1);
    check_eq("copy_wr_data",   s_wdata[3], 32'hA0);
    check_eq("copy_req_c1",    32'(s_req[1]), 32'd1);
    check_eq("copy_done_addr", s_addr[10], 32'd0);
    check_eq("copy_done_req",  32'(s_req[10]), 32'd0);

    // Zero length
    run_op(32'h100, 32'h240, 16'd0, 0, 0, 0, 0, 6);
    check_eq("zero_done_cyc", 32'(first_of(s_done, 6)), 32'd1);
    check_eq("zero_req_cnt",  32'(count_of(s_req, 6)), 32'd0);
    check_eq("zero_busy_cnt", 32'(count_of(s_busy, 6)), 32'd0);
    check_eq("zero_writes",   32'(wr_total), 32'd0);
    check_eq("zero_mem",      mem[144], 32'd0);

    // Grant withdrawn for cycles 3..5 (first WR)
    mem[448] = 32'hB0; mem[449] = 32'hB1;
    run_op(32'h700, 32'h800, 16'd2, 3, 3, 0, 0, 14);
    check_eq("stall_we_cnt",   32'(s_we[3] | s_we[4] | s_we[5]), 32'd0);
    check_eq("stall_addr_c4",  s_addr[4], 32'h800);
    check_eq("stall_we_c6",    32'(s_we[6]), 32'd1);
    check_eq("stall_wr0_once", 32'(wr_cnt[512]), 32'd1);
    check_eq("stall_wr1_once", 32'(wr_cnt[513]), 32'd1);
    check_eq("stall_mem0",     mem[512], 32'hB0);
    check_eq("stall_mem1",     mem[513], 32'hB1);
    check_eq("stall_done_cyc", 32'(first_of(s_done, 14)), 32'd9);
    check_eq("stall_writes",   32'(wr_total), 32'd2);

    // Source wrap at 2^32 with an ignored start in cycle 3
    mem[1022] = 32'h11; mem[1023] = 32'h22; mem[0] = 32'h33;
    run_op(32'hFFFF_FFF8, 32'h400, 16'd3, 0, 0, 3, 0, 20);
    check_eq("wrap_rd0",      s_addr[2], 32'hFFFF_FFF8);
    check_eq("wrap_rd1",      s_addr[4], 32'hFFFF_FFFC);
    check_eq("wrap_rd2",      s_addr[6], 32'h0000_0000);
    check_eq("wrap_mem0",     mem[256], 32'h11);
    check_eq("wrap_mem1",     mem[257], 32'h22);
    check_eq("wrap_mem2",     mem[258], 32'h33);
    check_eq("wrap_done_cyc", 32'(first_of(s_done, 20)), 32'd8);
    check_eq("wrap_done_cnt", 32'(count_of(s_done, 20)), 32'd1);
    check_eq("wrap_writes",   32'(wr_total), 32'd3);

    // Reset asserted in cycle 6 of an 8-word copy
    for (int i = 0; i < 8; i++) mem[320 + i] = 32'hC0 + 32'(i);
    run_op(32'h500, 32'h600, 16'd8, 0, 0, 0, 6, 14);
    check_eq("rmid_req",      32'(s_req[6]), 32'd0);
    check_eq("rmid_busy",     32'(s_busy[6]), 32'd0);
    check_eq("rmid_addr",     s_addr[6], 32'd0);
    check_eq("rmid_we",       32'(s_we[6]), 32'd0);
    check_eq("rmid_rem",      32'(s_rem[6]), 32'd0);
    check_eq("rmid_done_cnt", 32'(count_of(s_done, 14)), 32'd0);
    check_eq("rmid_writes",   32'(wr_total), 32'd2);
    check_eq("rmid_mem1",     mem[385], 32'hC1);
    check_eq("rmid_mem2",     mem[386], 32'd0);

`ifdef BUS_COPY_FILL_EN
    fill_mode = 1'b1; fill_data = 32'hDEAD_BEEF;
    run_op(32'h0, 32'h300, 16'd4, 0, 0, 0, 0, 12);
    fill_mode = 1'b0;
    for (int i = 0; i < 4; i++) check_eq($sformatf("fill_mem%0d", i), mem[192 + i], 32'hDEAD_BEEF);
    check_eq("fill_done_cyc", 32'(first_of(s_done, 12)), 32'd6);
    check_eq("fill_writes",   32'(wr_total), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
